// File: rtl/core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_pkg : register-file geometry shared by the RV32I core blocks
// Revision : 1.0
// ----------------------------------------------------------------------------
package core_pkg;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [NREG-1:0] busy_vec_t;

  localparam reg_idx_t REG_X0 = '0;
endpackage
`default_nettype wire

// File: rtl/sb_busy_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sb_busy_array : one busy flop per architectural register, set/clear ports
// Revision      : 1.0
// ----------------------------------------------------------------------------
module sb_busy_array
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   rs1_idx,
  input  logic [AW-1:0]   rs2_idx,
  input  logic [AW-1:0]   rd_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic [NREG-1:0] busy_vec
);

  busy_vec_t w_busy;

  // x0 has no flop: it can never hold a pending write
  assign w_busy[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_bit
    localparam reg_idx_t c_idx = reg_idx_t'(i);
    logic r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy <= 1'b0;
      end else if (set_en && set_idx == c_idx) begin
        r_busy <= 1'b1;
      end else if (clr_en && clr_idx == c_idx) begin
        r_busy <= 1'b0;
      end
    end

    assign w_busy[i] = r_busy;
  end

  assign rs1_busy = w_busy[rs1_idx];
  assign rs2_busy = w_busy[rs2_idx];
  assign rd_busy  = w_busy[rd_idx];
  assign busy_vec = w_busy;

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_scoreboard_ctrl : RAW/WAW hazard scoreboard and IF/ID, ID/EX enables
// Revision            : 1.0
// ----------------------------------------------------------------------------
module reg_scoreboard_ctrl
  import core_pkg::*;
#(
  parameter int CNTW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic            id_rs1_used,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_wen,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_wen,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            stall,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            id_ex_bubble,
  output logic            issue,
  output logic [NREG-1:0] busy_vec,
  output logic [CNTW-1:0] inflight,
  output logic            idle
);

  localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

  logic            w_rs1_busy, w_rs2_busy, w_rd_busy;
  logic            w_raw, w_waw, w_stall, w_issue;
  logic            w_set, w_clr;
  logic [CNTW-1:0] r_inflight;

  // Busy bits are registered, so a register retiring this cycle still reads busy
  assign w_raw = (id_rs1_used && id_rs1 != REG_X0 && w_rs1_busy) ||
                 (id_rs2_used && id_rs2 != REG_X0 && w_rs2_busy);
  assign w_waw = id_rd_wen && id_rd != REG_X0 && w_rd_busy;

  assign w_stall = rst_n && id_valid && !flush && (w_raw || w_waw);
  assign w_issue = rst_n && id_valid && !flush && !w_stall && !mem_stall;

  assign w_set = w_issue && id_rd_wen && id_rd != REG_X0;
  assign w_clr = wb_valid && wb_wen && wb_rd != REG_X0;

  sb_busy_array u_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (w_set),
    .set_idx  (id_rd),
    .clr_en   (w_clr),
    .clr_idx  (wb_rd),
    .rs1_idx  (id_rs1),
    .rs2_idx  (id_rs2),
    .rd_idx   (id_rd),
    .rs1_busy (w_rs1_busy),
    .rs2_busy (w_rs2_busy),
    .rd_busy  (w_rd_busy),
    .busy_vec (busy_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (w_set && !w_clr && r_inflight != c_cnt_max) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (w_clr && !w_set && r_inflight != '0) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  // Reset forces a frozen pipeline with a bubble in ID/EX
  assign stall        = w_stall;
  assign issue        = w_issue;
  assign if_id_en     = rst_n && !w_stall && !mem_stall;
  assign id_ex_en     = rst_n && !mem_stall;
  assign id_ex_bubble = !rst_n || (!mem_stall && (w_stall || flush || !id_valid));
  assign inflight     = r_inflight;
  assign idle         = !rst_n || (r_inflight == '0);

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_clr |-> busy_vec[wb_rd]);
  a_no_overflow  : assert property (@(posedge clk) disable iff (!rst_n)
    (w_set && !w_clr) |-> (r_inflight != c_cnt_max));

endmodule
`default_nettype wire
